vga_plot_arbiter: RTL and testbench
===================================

# vga_plot_arbiter

Round-robin arbiter that shares the single VGA plot port (x, y, colour, writeEn) among up to N independent draw units: the card-outline drawer, the symbol drawers and later overlay units. It replaces ad-hoc OR-ing of write enables, so only one unit can drive the pixel bus at a time. A grant is held for a whole primitive, with optional forced revocation so one long draw cannot starve the others. Sits between the draw units and the VGA adapter instance.

## Interface
Parameters:
- N, 4, number of requesters (2..8)
- MAX_HOLD, 0, maximum grant length in cycles while another request is pending; 0 disables revocation

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  N  req[i] held high by unit i for the duration of its primitive
- pix_valid  in  N  unit i presents a pixel this cycle
- x_in  in  8*N  packed x coordinates; unit i uses bits [8i+7:8i]
- y_in  in  7*N  packed y coordinates; unit i uses bits [7i+6:7i]
- colour_in  in  3*N  packed colours; unit i uses bits [3i+2:3i]
- gnt  out  N  one-hot grant, registered
- x  out  8  pixel x to VGA adapter, registered
- y  out  7  pixel y to VGA adapter, registered
- colour  out  3  pixel colour to VGA adapter, registered
- writeEn  out  1  plot strobe to VGA adapter, registered
- busy  out  1  high while any grant is active

## Operation
- States: IDLE and GRANT. The current owner index g is held in a register; a round-robin pointer ptr holds the highest-priority index.
- IDLE: if any req bit is high, pick the first i at or after ptr, scanning upward and wrapping mod N. Set gnt[i] and go to GRANT on the next edge. Otherwise stay in IDLE.
- GRANT: every cycle, register writeEn <= pix_valid[g] & req[g]. When that term is 1, also register x, y and colour from slice g. When it is 0, x, y and colour hold their previous values.
- Pixel consumption rule: unit i's pixel is consumed in any cycle where gnt[i] & req[i] & pix_valid[i]. Units advance their pixel only on consumption. pix_valid without a grant is ignored.
- Release: if req[g] is sampled low in GRANT, gnt clears on the next edge, ptr <= (g+1) mod N, and the state returns to IDLE.
- Revocation (MAX_HOLD > 0): a hold counter is cleared on entry to GRANT and increments each GRANT cycle. If it equals MAX_HOLD-1 and any other req bit is high, gnt clears on the next edge, ptr <= (g+1) mod N, and the state returns to IDLE.
  - The pixel offered in that last granted cycle is still written.
  - The revoked unit keeps req high and resumes from its current pixel when re-granted.
- Revocation never occurs when no other request is pending; the counter saturates at MAX_HOLD-1.
- busy = (state == GRANT).
- Simultaneous release and revoke condition: treated as release; result is identical.

## Timing
- Reset values: state IDLE, gnt=0, ptr=0, g=0, hold counter 0, x=0, y=0, colour=0, writeEn=0, busy=0.
- Reset mid-grant: all of the above are restored on the next edge; an in-flight pixel is dropped.
- Request to grant: req rises at cycle t (state IDLE), gnt is high at t+1.
- Pixel latency: pixel offered at cycle t with gnt high produces writeEn, x, y and colour at t+1.
- Sustained rate: one pixel per cycle while granted.
- Turnaround: one mandatory IDLE cycle (gnt=0, writeEn=0) between any two grants, including a re-grant to the same unit.
- gnt is always one-hot or zero; writeEn is never high in a cycle after gnt was zero.

## Test plan
- Reset: hold reset 3 cycles with req=4'b1111 -> gnt=0, writeEn=0, x=0, y=0, colour=0 throughout; after release, gnt=4'b0001 one cycle later.
- Single unit: unit 2 raises req and offers pixels (50,30,3'b111), (51,30,3'b111), (52,30,3'b111) on consecutive granted cycles -> writeEn high for exactly 3 cycles with those values, each one cycle after its pixel is offered; gnt=4'b0100.
- Round robin: req=4'b1011 held constant, each unit drops req after 2 pixels -> grant order 0, 1, 3, 0. Exactly one IDLE cycle between grants, with writeEn=0 in those cycles.
- Revocation, MAX_HOLD=4: unit 0 streams 10 pixels while unit 1 requests -> gnt[0] high exactly 4 cycles, 4 pixels written, then unit 1 is served. Unit 0 then resumes at its 5th pixel with no pixel lost or duplicated.
- No contention, MAX_HOLD=4: unit 0 alone streams 10 pixels -> never revoked; 10 consecutive writeEn pulses.
- Reset mid-grant: assert reset while unit 1 is mid-stream -> gnt=0 and writeEn=0 on the next edge; after release, arbitration restarts at unit 0.

Source files
------------

// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the single VGA plot port.
// Grants are held per primitive, with optional forced revocation.
module vga_plot_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   pix_valid,
    input  logic [8*N-1:0] x_in,
    input  logic [7*N-1:0] y_in,
    input  logic [3*N-1:0] colour_in,
    output logic [N-1:0]   gnt,
    output logic [7:0]     x,
    output logic [6:0]     y,
    output logic [2:0]     colour,
    output logic           writeEn,
    output logic           busy
);

    localparam int IW    = (N > 1) ? $clog2(N) : 1;
    localparam int HW    = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam int HLAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state, state_n;
    logic [IW-1:0]   g, g_n, ptr, ptr_n, pick, g_inc;
    logic [HW-1:0]   hold, hold_n;
    logic [N-1:0]    gnt_n, others;
    logic [2*N-1:0]  rot;
    logic            found, cons, hold_last, done, we_n;
    logic [7:0]      sel_x, x_n;
    logic [6:0]      sel_y, y_n;
    logic [2:0]      sel_c, c_n;
    logic            sel_req, sel_pv;
    int              tmp;

    // First requester at or after ptr, wrapping mod N.
    always_comb begin
        rot   = {req, req} >> ptr;
        found = 1'b0;
        pick  = '0;
        tmp   = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                tmp   = int'(ptr) + k;
                if (tmp >= N) tmp = tmp - N;
                pick  = IW'(tmp);
            end
        end
    end

    // Steer the current owner's request, strobe and pixel.
    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        sel_c   = '0;
        sel_req = 1'b0;
        sel_pv  = 1'b0;
        others  = req;
        for (int i = 0; i < N; i++) begin
            if (g == IW'(i)) begin
                sel_x     = x_in[8*i +: 8];
                sel_y     = y_in[7*i +: 7];
                sel_c     = colour_in[3*i +: 3];
                sel_req   = req[i];
                sel_pv    = pix_valid[i];
                others[i] = 1'b0;
            end
        end
    end

    assign cons      = sel_req & sel_pv;
    assign hold_last = (MAX_HOLD > 0) && (hold == HW'(HLAST));
    assign g_inc     = (int'(g) == N - 1) ? '0 : g + IW'(1);
    assign busy      = (state == GRANT);

    // Next state, grant and registered plot outputs.
    always_comb begin
        state_n = state;
        g_n     = g;
        ptr_n   = ptr;
        hold_n  = hold;
        gnt_n   = gnt;
        we_n    = 1'b0;
        x_n     = x;
        y_n     = y;
        c_n     = colour;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n     = GRANT;
                    g_n         = pick;
                    hold_n      = '0;
                    gnt_n       = '0;
                    gnt_n[pick] = 1'b1;
                end
            end
            GRANT: begin
                we_n = cons;
                if (cons) begin
                    x_n = sel_x;
                    y_n = sel_y;
                    c_n = sel_c;
                end
                done = !sel_req || (hold_last && (|others));
                if (done) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    ptr_n   = g_inc;
                end else if (MAX_HOLD > 0 && !hold_last) begin
                    hold_n = hold + HW'(1);
                end
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            g       <= '0;
            ptr     <= '0;
            hold    <= '0;
            gnt     <= '0;
            writeEn <= 1'b0;
            x       <= '0;
            y       <= '0;
            colour  <= '0;
        end else begin
            state   <= state_n;
            g       <= g_n;
            ptr     <= ptr_n;
            hold    <= hold_n;
            gnt     <= gnt_n;
            writeEn <= we_n;
            x       <= x_n;
            y       <= y_n;
            colour  <= c_n;
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter.
// Draw units and a transaction-level arbiter model live here.
module tb_vga_plot_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   pix_valid = '0;
    logic [8*N-1:0] x_in = '0;
    logic [7*N-1:0] y_in = '0;
    logic [3*N-1:0] colour_in = '0;
    logic [N-1:0]   gnt;
    logic [7:0]     x;
    logic [6:0]     y;
    logic [2:0]     colour;
    logic           writeEn;
    logic           busy;

    vga_plot_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
        .clk(clk), .reset(reset), .req(req), .pix_valid(pix_valid),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
        .gnt(gnt), .x(x), .y(y), .colour(colour),
        .writeEn(writeEn), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
    } pix_t;

    pix_t upix[N][$];
    int   plen[N][$];
    int   rem[N];
    bit   rand_pv = 0;
    pix_t sb[$];

    int total = 0;
    int passed = 0;
    bit mon_en = 0;

    // model of the arbiter, kept as plain integers
    bit           m_grant = 0;
    int           m_g = 0, m_ptr = 0, m_hold = 0;
    logic [N-1:0] m_gnt = '0;
    logic         m_we = 0;
    bit           n_grant;
    int           n_g, n_ptr, n_hold;
    logic         n_we;
    int           cons;

    int           gorder[$];
    int           glen[$];
    int           cur_len = 0, we_count = 0, cur_run = 0, max_run = 0;
    logic [N-1:0] prev_gnt = '0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic add_prim(input int u, input int len, input int bx,
                            input int by, input int bc);
        pix_t p;
        plen[u].push_back(len);
        for (int k = 0; k < len; k++) begin
            p.px = 8'(bx + k);
            p.py = 7'(by);
            p.pc = 3'(bc);
            upix[u].push_back(p);
        end
    endtask

    task automatic load_units(input bit [N-1:0] just);
        for (int i = 0; i < N; i++)
            if (rem[i] == 0 && !just[i] && plen[i].size() > 0)
                rem[i] = plen[i].pop_front();
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i] = (rem[i] > 0);
            if (req[i]) begin
                pix_valid[i] = rand_pv ? ($urandom_range(0, 3) != 0) : 1'b1;
                x_in[8*i +: 8]      = upix[i][0].px;
                y_in[7*i +: 7]      = upix[i][0].py;
                colour_in[3*i +: 3] = upix[i][0].pc;
            end else begin
                pix_valid[i] = rand_pv ? 1'($urandom_range(0, 1)) : 1'b0;
                x_in[8*i +: 8]      = 8'($urandom);
                y_in[7*i +: 7]      = 7'($urandom);
                colour_in[3*i +: 3] = 3'($urandom);
            end
        end
    endtask

    // next model state from the arbitration rules
    task automatic model_eval();
        bit oth;
        n_grant = m_grant;
        n_g     = m_g;
        n_ptr   = m_ptr;
        n_hold  = m_hold;
        n_we    = 1'b0;
        cons    = -1;
        if (reset) begin
            n_grant = 0; n_g = 0; n_ptr = 0; n_hold = 0;
        end else if (!m_grant) begin
            for (int k = 0; k < N; k++) begin
                if (!n_grant && req[(m_ptr + k) % N]) begin
                    n_grant = 1;
                    n_g     = (m_ptr + k) % N;
                    n_hold  = 0;
                end
            end
        end else begin
            if (req[m_g] && pix_valid[m_g]) begin
                cons = m_g;
                n_we = 1'b1;
                sb.push_back(upix[m_g][0]);
            end
            oth = 0;
            for (int i = 0; i < N; i++) if (i != m_g && req[i]) oth = 1;
            if (!req[m_g] || (m_hold == MH - 1 && oth)) begin
                n_grant = 0;
                n_ptr   = (m_g + 1) % N;
            end else if (m_hold < MH - 1) begin
                n_hold = m_hold + 1;
            end
        end
    endtask

    task automatic step();
        bit [N-1:0] just;
        just = '0;
        drive();
        model_eval();
        @(posedge clk);
        #1;
        m_grant = n_grant;
        m_g     = n_g;
        m_ptr   = n_ptr;
        m_hold  = n_hold;
        m_we    = n_we;
        m_gnt   = '0;
        if (m_grant) m_gnt[m_g] = 1'b1;
        if (cons >= 0) begin
            void'(upix[cons].pop_front());
            rem[cons]--;
            if (rem[cons] == 0) just[cons] = 1'b1;
        end
        load_units(just);
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < N; i++)
            if (rem[i] != 0 || plen[i].size() != 0) return 0;
        return !m_grant;
    endfunction

    task automatic run_idle(input int maxc);
        int n;
        n = 0;
        while (!all_idle() && n < maxc) begin
            step();
            n++;
        end
        if (n >= maxc) chk("drain_timeout", 0, 1);
        step();
        step();
        chk("sb_empty", sb.size(), 0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic clear_stats();
        gorder.delete();
        glen.delete();
        we_count = 0;
        max_run  = 0;
    endtask

    // monitor: compares DUT against model and scoreboard each cycle
    always @(negedge clk) begin
        pix_t e;
        if (mon_en) begin
            chk("gnt", int'(gnt), int'(m_gnt));
            chk("writeEn", int'(writeEn), int'(m_we));
            chk("busy", int'(busy), int'(m_grant));
            if (writeEn) begin
                we_count++;
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
                if (sb.size() == 0) begin
                    chk("unexpected_pixel", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("pixel", int'({x, y, colour}), int'(e));
                end
            end else begin
                cur_run = 0;
            end
            if (gnt != '0) begin
                if (prev_gnt == '0) begin
                    gorder.push_back(oh_idx(gnt));
                    cur_len = 0;
                end
                cur_len++;
            end else if (prev_gnt != '0) begin
                glen.push_back(cur_len);
            end
            prev_gnt = gnt;
        end
    end

    initial begin
        int exp3[4];
        exp3 = '{0, 1, 3, 0};
        for (int i = 0; i < N; i++) rem[i] = 0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1;

        // reset held with all units requesting
        for (int i = 0; i < N; i++) add_prim(i, 1, 10 + i, 5, i);
        load_units('0);
        repeat (3) begin
            step();
            chk("rst_gnt", int'(gnt), 0);
            chk("rst_we", int'(writeEn), 0);
            chk("rst_xyc", int'({x, y, colour}), 0);
        end
        reset = 1'b0;
        step();
        chk("gnt_after_reset", int'(gnt), 1);
        run_idle(200);

        // single unit
        apply_reset();
        clear_stats();
        add_prim(2, 3, 50, 30, 7);
        load_units('0);
        run_idle(100);
        chk("single_we_count", we_count, 3);
        chk("single_run", max_run, 3);
        chk("single_grants", gorder.size(), 1);
        chk("single_unit", gorder[0], 2);

        // round robin
        apply_reset();
        clear_stats();
        add_prim(0, 2, 0, 1, 1);
        add_prim(0, 2, 8, 1, 2);
        add_prim(1, 2, 16, 2, 3);
        add_prim(3, 2, 24, 3, 4);
        load_units('0);
        run_idle(200);
        chk("rr_grants", gorder.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk("rr_order", gorder[k], exp3[k]);
            chk("rr_len", glen[k], 3);
        end
        chk("rr_we_count", we_count, 8);

        // revocation under contention
        apply_reset();
        clear_stats();
        add_prim(0, 10, 100, 40, 1);
        add_prim(1, 3, 20, 20, 4);
        load_units('0);
        run_idle(200);
        chk("rev_grants", gorder.size(), 3);
        chk("rev_first", gorder[0], 0);
        chk("rev_second", gorder[1], 1);
        chk("rev_third", gorder[2], 0);
        chk("rev_hold", glen[0], 4);
        chk("rev_we_count", we_count, 13);

        // no contention, never revoked
        apply_reset();
        clear_stats();
        add_prim(0, 10, 60, 60, 5);
        load_units('0);
        run_idle(200);
        chk("solo_we_count", we_count, 10);
        chk("solo_run", max_run, 10);
        chk("solo_grants", gorder.size(), 1);
        chk("solo_len", glen[0], 11);

        // reset mid-grant
        apply_reset();
        clear_stats();
        add_prim(1, 8, 140, 70, 6);
        load_units('0);
        repeat (4) step();
        chk("mid_gnt_before", int'(gnt), 2);
        add_prim(0, 2, 200, 10, 2);
        load_units('0);
        reset = 1'b1;
        step();
        chk("mid_rst_gnt", int'(gnt), 0);
        chk("mid_rst_we", int'(writeEn), 0);
        reset = 1'b0;
        clear_stats();
        run_idle(200);
        chk("mid_restart", gorder[0], 0);
        chk("mid_next", gorder[1], 1);

        // randomized traffic
        apply_reset();
        rand_pv = 1;
        repeat (4) begin
            for (int i = 0; i < N; i++) begin
                add_prim(i, $urandom_range(1, 7), $urandom_range(0, 255),
                         $urandom_range(0, 119), $urandom_range(0, 7));
                add_prim(i, $urandom_range(1, 7), $urandom_range(0, 255),
                         $urandom_range(0, 119), $urandom_range(0, 7));
            end
            load_units('0);
            run_idle(3000);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
